// File: rtl/rsa_pkg.sv
// -----------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the RSA operand loader: segment tags, segment
// geometry and base addresses in the input SRAM, and the loader FSM state type.
// -----------------------------------------------------------------------------
package rsa_pkg;

    // Segment geometry of the input SRAM image.
    localparam int SEG_WORDS    = 64;
    localparam int SEG_COUNT    = 3;

    // Base word address of each segment.
    localparam int SEG_BASE_MSG = 0;
    localparam int SEG_BASE_KEY = SEG_WORDS;
    localparam int SEG_BASE_MOD = 2 * SEG_WORDS;

    // Segment tag carried with every operand word.
    typedef enum logic [1:0] {
        SEG_MSG = 2'd0,
        SEG_KEY = 2'd1,
        SEG_MOD = 2'd2
    } seg_e;

    // Loader control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_e;

endpackage

// File: rtl/rsa_operand_loader_if.sv
// -----------------------------------------------------------------------------
// rsa_operand_loader_if
// Groups the SRAM read port and the operand stream toward the RSA core.
//   sram_en / sram_addr   : read request (loader -> SRAM)
//   sram_data             : read data, one cycle after sram_en (SRAM -> loader)
//   out_valid/out_ready   : operand stream handshake
//   out_data/out_seg/out_idx/out_last : operand word and its tag
// Modports:
//   master : the loader
//   slave  : the SRAM + RSA core side
// -----------------------------------------------------------------------------
interface rsa_operand_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int IDX_W  = 6
);
    logic              sram_en;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_seg;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;

    modport master (
        output sram_en, sram_addr,
        input  sram_data,
        output out_valid, out_data, out_seg, out_idx, out_last,
        input  out_ready
    );

    modport slave (
        input  sram_en, sram_addr,
        output sram_data,
        input  out_valid, out_data, out_seg, out_idx, out_last,
        output out_ready
    );
endinterface

// File: rtl/rsa_skid_fifo.sv
// -----------------------------------------------------------------------------
// rsa_skid_fifo
// Two-entry fall-through FIFO for tagged operand words.
// When empty, a pushed word is presented on the head in the same cycle, so a
// word returning from the SRAM can be consumed without an extra register stage.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset (flushes the FIFO)
//   i_push/i_din: write strobe and payload
//   i_pop       : consume head (caller only pops when o_valid)
//   o_valid     : head holds a word (stored or bypassing)
//   o_head      : head payload, zero when nothing is valid
//   o_count     : number of stored entries (0..2)
// -----------------------------------------------------------------------------
module rsa_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_count
);
    logic [W-1:0] r_mem [2];
    logic         r_rd;
    logic         r_wr;
    logic [1:0]   r_cnt;

    logic w_empty;
    logic w_bypass;
    logic w_wr;
    logic w_rd;

    assign w_empty  = (r_cnt == 2'd0);
    // Word arriving into an empty FIFO and taken the same cycle never lands.
    assign w_bypass = i_push && i_pop && w_empty;
    assign w_wr     = i_push && !w_bypass;
    assign w_rd     = i_pop && !w_empty;

    assign o_valid  = !w_empty || i_push;
    assign o_head   = !w_empty ? r_mem[r_rd] : (i_push ? i_din : '0);
    assign o_count  = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd  <= 1'b0;
            r_wr  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (w_wr) r_wr <= ~r_wr;
            if (w_rd) r_rd <= ~r_rd;
            r_cnt <= r_cnt + 2'(w_wr) - 2'(w_rd);
        end
    end

    // Storage needs no reset: it is only observed when r_cnt is non-zero.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr] <= i_din;
    end
endmodule

// File: rtl/rsa_operand_loader.sv
// -----------------------------------------------------------------------------
// rsa_operand_loader
// Streams the MSG, KEY and MOD segments out of the input SRAM (ascending word
// addresses) to the modular-exponentiation core over valid/ready. Absorbs the
// one-cycle SRAM read latency and downstream backpressure through a 2-entry
// skid FIFO; a read is issued only if its word is guaranteed a FIFO slot.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : begin a load (accepted in IDLE only)
//   busy      : load in progress (FETCH/DRAIN)
//   done      : one-cycle pulse after the last MOD word is accepted
//   checksum  : XOR of all accepted words (only with RSA_LOADER_CHECKSUM_EN)
//   bus       : SRAM read port + operand stream (master modport)
// Build option: define RSA_LOADER_CHECKSUM_EN to add the checksum port/logic.
// -----------------------------------------------------------------------------
module rsa_operand_loader
    import rsa_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int SEG_WORDS = rsa_pkg::SEG_WORDS,
    parameter int SEG_COUNT = rsa_pkg::SEG_COUNT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
`ifdef RSA_LOADER_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    rsa_operand_loader_if.master bus
);
    localparam int IDX_W = $clog2(SEG_WORDS);
    localparam int ENT_W = DATA_W + 2 + IDX_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SEG_COUNT * SEG_WORDS - 1);
    localparam logic [1:0]        LAST_SEG  = 2'(SEG_COUNT - 1);

    ld_state_e         r_state;
    ld_state_e         w_state_nxt;

    logic [ADDR_W-1:0] r_cnt;
    logic              r_inflight;
    logic [1:0]        r_if_seg;
    logic [IDX_W-1:0]  r_if_idx;
    logic              r_if_last;

    logic              w_start_acc;
    logic              w_issue;
    logic              w_pop;
    logic              w_final_pop;
    logic [2:0]        w_occ;
    logic [1:0]        w_fifo_cnt;
    logic              w_valid;
    logic [ENT_W-1:0]  w_push_ent;
    logic [ENT_W-1:0]  w_head;
    logic [DATA_W-1:0] w_head_data;
    logic [1:0]        w_head_seg;
    logic [IDX_W-1:0]  w_head_idx;
    logic              w_head_last;
    logic [1:0]        w_rd_seg;
    logic [IDX_W-1:0]  w_rd_idx;

    // ---------------------------------------------------------------- control
    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_pop       = w_valid && bus.out_ready;

    // Slots committed after this cycle: stored + returning - leaving.
    // Underflow is impossible since a pop needs a stored or returning word.
    assign w_occ   = {1'b0, w_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = (r_state == ST_FETCH) && (w_occ < 3'd2);

    assign w_final_pop = w_pop && w_head_last && (w_head_seg == LAST_SEG);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_FETCH;
            ST_FETCH: if (w_issue && (r_cnt == LAST_ADDR)) w_state_nxt = ST_DRAIN;
            // The final MOD word is the last one in flight, so its acceptance
            // means the FIFO and the read pipe are both empty.
            ST_DRAIN: if (w_final_pop) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
    assign done = (r_state == ST_DONE);

    // ------------------------------------------------------------ read issue
    // Counter stops on the last address so sram_addr holds after the load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_start_acc) begin
            r_cnt <= '0;
        end else if (w_issue && (r_cnt != LAST_ADDR)) begin
            r_cnt <= r_cnt + ADDR_W'(1);
        end
    end

    assign w_rd_seg = 2'(r_cnt >> IDX_W);
    assign w_rd_idx = r_cnt[IDX_W-1:0];

    // Tag of the read whose data returns next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_if_seg   <= 2'd0;
            r_if_idx   <= '0;
            r_if_last  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_if_seg  <= w_rd_seg;
                r_if_idx  <= w_rd_idx;
                r_if_last <= &w_rd_idx;
            end
        end
    end

    assign bus.sram_en   = w_issue;
    assign bus.sram_addr = r_cnt;

    // ------------------------------------------------------------- skid FIFO
    assign w_push_ent = {bus.sram_data, r_if_seg, r_if_idx, r_if_last};

    rsa_skid_fifo #(
        .W (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_din   (w_push_ent),
        .i_pop   (w_pop),
        .o_valid (w_valid),
        .o_head  (w_head),
        .o_count (w_fifo_cnt)
    );

    assign {w_head_data, w_head_seg, w_head_idx, w_head_last} = w_head;

    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_head_data;
    assign bus.out_seg   = w_head_seg;
    assign bus.out_idx   = w_head_idx;
    assign bus.out_last  = w_head_last;

    // -------------------------------------------------------------- checksum
`ifdef RSA_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_start_acc) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum ^ w_head_data;
        end
    end

    assign checksum = r_checksum;
`else
    // No running checksum in this build.
`endif

endmodule

// File: tb/tb_rsa_operand_loader.sv
module tb_rsa_operand_loader;
    import rsa_pkg::*;

    localparam int NW = 192;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;
`ifdef RSA_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    rsa_operand_loader_if bus ();

    logic [31:0] mem [256];
    logic [31:0] sram_q = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int rx_cnt  = 0;
    int iss_cnt = 0;
    int done_cnt = 0;
    logic        mon_stall = 1'b0;
    logic [40:0] mon_prev  = '0;

    always #5 clk = ~clk;

    // SRAM model: registered read, data valid the cycle after sram_en.
    always @(posedge clk) if (bus.sram_en) sram_q <= mem[bus.sram_addr];
    assign bus.sram_data = sram_q;

    rsa_operand_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
`ifdef RSA_LOADER_CHECKSUM_EN
        .checksum (checksum),
`endif
        .bus      (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [40:0] exp_word(input int i);
        return {2'(i / 64), 6'(i % 64), 1'((i % 64) == 63), mem[i[7:0]]};
    endfunction

    function automatic logic [40:0] cur_word();
        return {bus.out_seg, bus.out_idx, bus.out_last, bus.out_data};
    endfunction

    // Stream monitor: order/content scoreboard and stall-hold check.
    always @(negedge clk) begin
        if (rst) begin
            mon_stall = 1'b0;
        end else begin
            if (bus.sram_en) iss_cnt++;
            if (done) done_cnt++;
            if (mon_stall) check("hold", 64'(cur_word()), 64'(mon_prev));
            if (bus.out_valid && bus.out_ready) begin
                check("word", 64'(cur_word()), 64'(exp_word(rx_cnt)));
                rx_cnt++;
            end
            mon_stall = bus.out_valid && !bus.out_ready;
            mon_prev  = cur_word();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        rx_cnt = 0; iss_cnt = 0; done_cnt = 0;
    endtask

    // mode 0: ready high, 1: toggle each cycle, 2: random
    task automatic run_until_done(input int mode, inout int lat);
        while (!done && lat < 3000) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (lat % 2) == 0;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            step();
            lat++;
        end
        check("done_seen", 64'(done), 64'd1);
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int lat;
        int en_stall;
        int ahead_max;
        int r0;
        logic pulsed;
        logic [31:0] model;

        bus.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'(i);

        // ---- reset state
        step(); step();
        check("rst_en_addr", {63'd0, bus.sram_en} | 64'(bus.sram_addr), 64'd0);
        check("rst_valid",   64'(bus.out_valid), 64'd0);
        check("rst_head",    64'(cur_word()), 64'd0);
        check("rst_busy_done", 64'({busy, done}), 64'd0);
        rst = 1'b0;
        step();

        // ---- free run, word[i] = i
        clr_counts();
        kick();
        lat = 1;
        check("t1_en",    64'(bus.sram_en), 64'd1);
        check("t1_addr",  64'(bus.sram_addr), 64'd0);
        check("t1_busy",  64'(busy), 64'd1);
        check("t1_valid", 64'(bus.out_valid), 64'd0);
        step(); lat++;
        check("t2_valid", 64'(bus.out_valid), 64'd1);
        check("t2_head",  64'(cur_word()), 64'(exp_word(0)));
        run_until_done(0, lat);
        check("done_lat", 64'(lat), 64'd194);
        check("fr_rx",    64'(rx_cnt), 64'(NW));
        step();
        check("fr_done_pulse", 64'({busy, done}), 64'd0);
        check("fr_done_cnt",   64'(done_cnt), 64'd1);
        check("fr_addr_hold",  64'(bus.sram_addr), 64'd191);

        // ---- backpressure: 1-cycle high/low
        for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'd3 + 32'h1000_0007;
        clr_counts();
        kick(); lat = 1;
        run_until_done(1, lat);
        check("bp_rx", 64'(rx_cnt), 64'(NW));
        step();
        check("bp_done_cnt", 64'(done_cnt), 64'd1);

        // ---- long stall from word 5
        for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'd7 + 32'hC0DE_0000;
        clr_counts();
        bus.out_ready = 1'b1;
        kick(); lat = 1;
        while (rx_cnt < 5 && lat < 100) begin step(); lat++; end
        check("ls_reach5", 64'(rx_cnt), 64'd5);
        bus.out_ready = 1'b0;
        en_stall = 0; ahead_max = 0;
        for (int s = 0; s < 20; s++) begin
            step();
            if (s < 19 && bus.sram_en) en_stall++;
            if (iss_cnt - rx_cnt - 1 > ahead_max) ahead_max = iss_cnt - rx_cnt - 1;
        end
        check("ls_no_en",   64'(en_stall), 64'd0);
        check("ls_ahead_le2", 64'(ahead_max <= 2), 64'd1);
        check("ls_head",    64'(cur_word()), 64'(exp_word(5)));
        bus.out_ready = 1'b1;
        r0 = rx_cnt;
        for (int s = 0; s < 10; s++) step();
        check("ls_resume_rate", 64'(rx_cnt - r0), 64'd10);
        lat = 0;
        run_until_done(0, lat);
        check("ls_rx", 64'(rx_cnt), 64'(NW));
        step();

        // ---- start while busy at word 100
        for (int i = 0; i < 256; i++) mem[i] = 32'(i) ^ 32'h5A5A_0000;
        clr_counts();
        kick(); lat = 1;
        pulsed = 1'b0;
        while (!done && lat < 3000) begin
            start = (rx_cnt >= 100) && !pulsed;
            if (start) pulsed = 1'b1;
            step(); lat++;
            start = 1'b0;
        end
        check("sb_lat", 64'(lat), 64'd194);
        for (int s = 0; s < 4; s++) step();
        check("sb_rx",       64'(rx_cnt), 64'(NW));
        check("sb_done_cnt", 64'(done_cnt), 64'd1);
        check("sb_issues",   64'(iss_cnt), 64'(NW));
        check("sb_idle",     64'(busy), 64'd0);

        // ---- reset mid-load at word 70
        for (int i = 0; i < 256; i++) mem[i] = ~32'(i);
        clr_counts();
        kick(); lat = 1;
        while (rx_cnt < 70 && lat < 300) begin step(); lat++; end
        rst = 1'b1;
        #1;
        check("mr_outs", 64'({bus.sram_en, bus.sram_addr, bus.out_valid}), 64'd0);
        check("mr_head", 64'(cur_word()), 64'd0);
        check("mr_busy_done", 64'({busy, done}), 64'd0);
        step();
        rst = 1'b0;
        step();
        clr_counts();
        kick(); lat = 1;
        check("mr_restart_addr", 64'({bus.sram_en, bus.sram_addr}), {55'd0, 1'b1, 8'd0});
        step(); lat++;
        check("mr_restart_head", 64'(cur_word()), 64'(exp_word(0)));
        run_until_done(0, lat);
        check("mr_lat", 64'(lat), 64'd194);
        check("mr_rx",  64'(rx_cnt), 64'(NW));
        step();

`ifdef RSA_LOADER_CHECKSUM_EN
        // ---- checksum with random stalls, three patterns
        for (int p = 0; p < 3; p++) begin
            model = '0;
            for (int i = 0; i < 256; i++) begin
                case (p)
                    0:       mem[i] = 32'(i) * 32'h9E37_79B9;
                    1:       mem[i] = 32'(i);
                    default: mem[i] = 32'hA5A5_0000 | 32'(i);
                endcase
                if (i < NW) model ^= mem[i];
            end
            clr_counts();
            kick(); lat = 1;
            if (p == 1) check("cs_cleared", 64'(checksum), 64'd0);
            run_until_done(2, lat);
            check("cs_at_done", 64'(checksum), 64'(model));
            check("cs_rx", 64'(rx_cnt), 64'(NW));
            step(); step();
            check("cs_held", 64'(checksum), 64'(model));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
